// File: rtl/sram_owner_sequencer_if.sv
// Bundle of the sequencer's master-facing and SRAM-facing signals.
// The sequencer attaches through the slave modport. Whoever drives the
// masters' requests (a top level or a bench) attaches through the master
// modport.
interface sram_owner_sequencer_if;
    // Flow control
    logic        Start;
    logic        DEC_done;

    // Master request ports
    logic [17:0] UART_SRAM_address;
    logic [15:0] UART_SRAM_write_data;
    logic        UART_SRAM_we_n;
    logic [17:0] DEC_SRAM_address;
    logic [15:0] DEC_SRAM_write_data;
    logic        DEC_SRAM_we_n;
    logic [17:0] VGA_SRAM_address;

    // Muxed SRAM port
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    // Sequencing controls and status
    logic        UART_initialize;
    logic        UART_enable;
    logic        DEC_start;
    logic        VGA_enable;
    logic [1:0]  Owner;
    logic [17:0] Word_count;
    logic        Busy;

    modport slave (
        input  Start, DEC_done,
        input  UART_SRAM_address, UART_SRAM_write_data, UART_SRAM_we_n,
        input  DEC_SRAM_address, DEC_SRAM_write_data, DEC_SRAM_we_n,
        input  VGA_SRAM_address,
        output SRAM_address, SRAM_write_data, SRAM_we_n,
        output UART_initialize, UART_enable, DEC_start, VGA_enable,
        output Owner, Word_count, Busy
    );

    modport master (
        output Start, DEC_done,
        output UART_SRAM_address, UART_SRAM_write_data, UART_SRAM_we_n,
        output DEC_SRAM_address, DEC_SRAM_write_data, DEC_SRAM_we_n,
        output VGA_SRAM_address,
        input  SRAM_address, SRAM_write_data, SRAM_we_n,
        input  UART_initialize, UART_enable, DEC_start, VGA_enable,
        input  Owner, Word_count, Busy
    );
endinterface

// File: rtl/sram_owner_sequencer.sv
// Sequences UART load -> decode -> VGA display and hands the single SRAM
// port to exactly one master per phase. Every control output is registered
// and decoded from the next state. The SRAM mux is combinational from the
// registered owner, so it adds no latency to the master signals.
module sram_owner_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    sram_owner_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UART_INIT,
        S_UART_RX,
        S_GUARD_A,
        S_DECODE,
        S_GUARD_B,
        S_DISPLAY
    } state_e;

    // Owner encoding seen on the Owner port.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_UART = 2'd1;
    localparam logic [1:0] OWN_DEC  = 2'd2;
    localparam logic [1:0] OWN_VGA  = 2'd3;

    // Value of the idle counter on the cycle the load phase ends.
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic               uart_init_q, uart_init_d;
    logic               uart_en_q, uart_en_d;
    logic               dec_start_q, dec_start_d;
    logic               vga_en_q, vga_en_d;
    logic               busy_q, busy_d;
    logic [17:0]        word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic               seen_write_q, seen_write_d;
    logic               we_prev_q, we_prev_d;

    logic               uart_we_n;
    assign uart_we_n = bus.UART_SRAM_we_n;

    // Next-state, load bookkeeping and registered-output decode.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        seen_write_d = seen_write_q;
        we_prev_d    = uart_we_n;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) state_d = S_UART_INIT;
            end
            S_UART_INIT: begin
                state_d = S_UART_RX;
            end
            S_UART_RX: begin
                // A new word is the falling edge of the loader's write enable.
                if (we_prev_q && !uart_we_n) begin
                    word_cnt_d   = word_cnt_q + 18'd1;
                    seen_write_d = 1'b1;
                end
                // Any write cycle restarts the idle window, so a write that
                // lands on the expiring edge keeps the load alive.
                if (!uart_we_n) begin
                    idle_cnt_d = '0;
                end else if (seen_write_q) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                if (uart_we_n && seen_write_q && idle_cnt_d == IDLE_LAST) begin
                    state_d = S_GUARD_A;
                end
            end
            S_GUARD_A: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // The start pulse marks the first decode cycle, on which a
                // stale done from the previous run is ignored.
                if (!dec_start_q && bus.DEC_done) state_d = S_GUARD_B;
            end
            S_GUARD_B: begin
                state_d = S_DISPLAY;
            end
            S_DISPLAY: begin
                if (bus.Start) state_d = S_UART_INIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering a load clears the count so it is already 0 while
        // Initialize is high.
        if (state_d == S_UART_INIT) begin
            word_cnt_d   = '0;
            idle_cnt_d   = '0;
            seen_write_d = 1'b0;
        end

        owner_d = OWN_NONE;
        case (state_d)
            S_UART_INIT, S_UART_RX: owner_d = OWN_UART;
            S_DECODE:               owner_d = OWN_DEC;
            S_DISPLAY:              owner_d = OWN_VGA;
            default:                owner_d = OWN_NONE;
        endcase

        uart_init_d = (state_d == S_UART_INIT);
        uart_en_d   = (state_d == S_UART_RX);
        dec_start_d = (state_d == S_DECODE) && (state_q != S_DECODE);
        vga_en_d    = (state_d == S_DISPLAY);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DISPLAY);
    end

    // State and registered outputs; reset returns to idle mid-phase.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            uart_init_q  <= 1'b0;
            uart_en_q    <= 1'b0;
            dec_start_q  <= 1'b0;
            vga_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            word_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            seen_write_q <= 1'b0;
            we_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            uart_init_q  <= uart_init_d;
            uart_en_q    <= uart_en_d;
            dec_start_q  <= dec_start_d;
            vga_en_q     <= vga_en_d;
            busy_q       <= busy_d;
            word_cnt_q   <= word_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            seen_write_q <= seen_write_d;
            we_prev_q    <= we_prev_d;
        end
    end

    // SRAM port mux; only the UART and decoder owners can ever write.
    always_comb begin
        bus.SRAM_address    = '0;
        bus.SRAM_write_data = '0;
        bus.SRAM_we_n       = 1'b1;
        case (owner_q)
            OWN_UART: begin
                bus.SRAM_address    = bus.UART_SRAM_address;
                bus.SRAM_write_data = bus.UART_SRAM_write_data;
                bus.SRAM_we_n       = bus.UART_SRAM_we_n;
            end
            OWN_DEC: begin
                bus.SRAM_address    = bus.DEC_SRAM_address;
                bus.SRAM_write_data = bus.DEC_SRAM_write_data;
                bus.SRAM_we_n       = bus.DEC_SRAM_we_n;
            end
            OWN_VGA: begin
                bus.SRAM_address    = bus.VGA_SRAM_address;
            end
            default: begin
                bus.SRAM_address    = '0;
            end
        endcase
    end

    assign bus.Owner           = owner_q;
    assign bus.UART_initialize = uart_init_q;
    assign bus.UART_enable     = uart_en_q;
    assign bus.DEC_start       = dec_start_q;
    assign bus.VGA_enable      = vga_en_q;
    assign bus.Busy            = busy_q;
    assign bus.Word_count      = word_cnt_q;

endmodule

// File: tb/tb_sram_owner_sequencer.sv
// Randomized bench for sram_owner_sequencer. A phase-level reference model
// uses cycle timestamps to predict every output on every cycle.
module tb_sram_owner_sequencer;

    localparam int T  = 8;
    localparam int CW = 4;

    localparam int P_IDLE = 0, P_INIT = 1, P_RX = 2, P_GA = 3,
                   P_DEC  = 4, P_GB   = 5, P_DISP = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_owner_sequencer_if bus();

    sram_owner_sequencer #(
        .TIMEOUT_CYCLES(T),
        .CNT_W         (CW)
    ) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int dec_pulses = 0;

    // Reference model state.
    int phase;
    int words;
    bit seen;
    int last_low;
    int dec_entry;
    bit prev_we;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        phase     = P_IDLE;
        words     = 0;
        seen      = 1'b0;
        last_low  = 0;
        dec_entry = -1;
        prev_we   = 1'b1;
    endtask

    // One clock edge of the flow, evaluated from the inputs present in cycle cyc.
    task automatic model_step();
        case (phase)
            P_IDLE, P_DISP: begin
                if (bus.Start) begin
                    phase = P_INIT;
                    words = 0;
                    seen  = 1'b0;
                end
            end
            P_INIT: phase = P_RX;
            P_RX: begin
                if (prev_we && !bus.UART_SRAM_we_n) begin
                    words = (words + 1) % 262144;
                    seen  = 1'b1;
                end
                if (!bus.UART_SRAM_we_n) last_low = cyc;
                else if (seen && (cyc - last_low) == T - 1) phase = P_GA;
            end
            P_GA: begin
                phase     = P_DEC;
                dec_entry = cyc + 1;
            end
            P_DEC: if (cyc != dec_entry && bus.DEC_done) phase = P_GB;
            P_GB:  phase = P_DISP;
            default: phase = P_IDLE;
        endcase
        prev_we = bus.UART_SRAM_we_n;
        cyc++;
    endtask

    function automatic logic [1:0] exp_owner();
        case (phase)
            P_INIT, P_RX: return 2'd1;
            P_DEC:        return 2'd2;
            P_DISP:       return 2'd3;
            default:      return 2'd0;
        endcase
    endfunction

    task automatic check_outputs();
        logic [1:0]  eo;
        logic [17:0] ea;
        logic [15:0] ed;
        logic        ew;
        eo = exp_owner();
        ea = 18'd0;
        ed = 16'd0;
        ew = 1'b1;
        if (eo == 2'd1) begin
            ea = bus.UART_SRAM_address; ed = bus.UART_SRAM_write_data; ew = bus.UART_SRAM_we_n;
        end else if (eo == 2'd2) begin
            ea = bus.DEC_SRAM_address; ed = bus.DEC_SRAM_write_data; ew = bus.DEC_SRAM_we_n;
        end else if (eo == 2'd3) begin
            ea = bus.VGA_SRAM_address;
        end
        check("owner",      32'(bus.Owner),           32'(eo));
        check("uart_init",  32'(bus.UART_initialize), 32'(phase == P_INIT));
        check("uart_en",    32'(bus.UART_enable),     32'(phase == P_RX));
        check("dec_start",  32'(bus.DEC_start),       32'(phase == P_DEC && cyc == dec_entry));
        check("vga_en",     32'(bus.VGA_enable),      32'(phase == P_DISP));
        check("busy",       32'(bus.Busy),            32'(phase != P_IDLE && phase != P_DISP));
        check("word_count", 32'(bus.Word_count),      32'(words));
        check("sram_addr",  32'(bus.SRAM_address),    32'(ea));
        check("sram_data",  32'(bus.SRAM_write_data), 32'(ed));
        check("sram_we_n",  32'(bus.SRAM_we_n),       32'(ew));
    endtask

    // Apply one edge with the currently driven inputs, then compare.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        dec_pulses += int'(bus.DEC_start);
        check_outputs();
    endtask

    task automatic randomize_masters();
        bus.DEC_SRAM_address    = 18'($urandom);
        bus.DEC_SRAM_write_data = 16'($urandom);
        bus.DEC_SRAM_we_n       = 1'($urandom);
        bus.VGA_SRAM_address    = 18'($urandom);
    endtask

    // UART idle cycles, optionally with Start noise that must be ignored.
    task automatic uart_idle(input int n, input bit start_noise);
        for (int k = 0; k < n; k++) begin
            randomize_masters();
            bus.UART_SRAM_address    = 18'($urandom);
            bus.UART_SRAM_write_data = 16'($urandom);
            bus.UART_SRAM_we_n       = 1'b1;
            bus.Start                = start_noise ? 1'($urandom) : 1'b0;
            tick();
            bus.Start = 1'b0;
        end
    endtask

    task automatic uart_word(input logic [17:0] addr, input int low_len);
        for (int k = 0; k < low_len; k++) begin
            randomize_masters();
            bus.UART_SRAM_address    = addr;
            bus.UART_SRAM_write_data = 16'($urandom);
            bus.UART_SRAM_we_n       = 1'b0;
            tick();
        end
        bus.UART_SRAM_we_n = 1'b1;
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    initial begin
        int n;
        int nwords;
        model_reset();
        bus.Start                = 1'b0;
        bus.DEC_done             = 1'b0;
        bus.UART_SRAM_address    = 18'h3FFFF;
        bus.UART_SRAM_write_data = 16'hFFFF;
        bus.UART_SRAM_we_n       = 1'b0;
        bus.DEC_SRAM_address     = 18'h1234;
        bus.DEC_SRAM_write_data  = 16'hBEEF;
        bus.DEC_SRAM_we_n        = 1'b0;
        bus.VGA_SRAM_address     = 18'h2AAAA;

        // Reset state, with masters driving writes that must not pass.
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check("rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.UART_SRAM_we_n = 1'b1;
        uart_idle(3, 1'b0);

        // Load 1: four words at 76800.., two low cycles each.
        pulse_start();
        uart_idle(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            uart_word(18'(76800 + i), 2);
            if (i < 3) uart_idle(int'($urandom_range(1, 3)), 1'b1);
        end
        // Measure the idle timeout from the last low cycle.
        n = 1;
        while (bus.Owner != 2'd0 && n < 4 * T) begin
            uart_idle(1, 1'b1);
            n++;
        end
        check("guard_a_delay", 32'(n), 32'(T));
        check("load1_words", 32'(bus.Word_count), 32'd4);

        // Decode: a done on the first cycle is ignored.
        dec_pulses = 0;
        uart_idle(1, 1'b0);
        check("dec_start_first", 32'(bus.DEC_start), 32'd1);
        bus.DEC_done = 1'b1;
        bus.DEC_SRAM_we_n = 1'b0;
        tick();
        bus.DEC_done = 1'b0;
        check("done_ignored_owner", 32'(bus.Owner), 32'd2);
        for (int k = 0; k < 9; k++) begin
            randomize_masters();
            tick();
        end
        bus.DEC_done = 1'b1;
        bus.DEC_SRAM_we_n = 1'b0;
        tick();
        bus.DEC_done = 1'b0;
        check("guard_b_we_n", 32'(bus.SRAM_we_n), 32'd1);
        tick();
        check("vga_after_done", 32'(bus.VGA_enable), 32'd1);
        check("dec_pulse_count", 32'(dec_pulses), 32'd1);

        // Display: VGA owns the port read-only.
        bus.VGA_SRAM_address = 18'h12C00;
        bus.UART_SRAM_we_n   = 1'b0;
        bus.DEC_SRAM_we_n    = 1'b0;
        tick();
        check("vga_addr", 32'(bus.SRAM_address), 32'h12C00);
        check("vga_we_n", 32'(bus.SRAM_we_n), 32'd1);
        bus.UART_SRAM_we_n = 1'b1;
        uart_idle(3, 1'b0);

        // Restart from display.
        pulse_start();
        check("restart_init", 32'(bus.UART_initialize), 32'd1);
        check("restart_count", 32'(bus.Word_count), 32'd0);
        check("restart_vga", 32'(bus.VGA_enable), 32'd0);
        uart_idle(1, 1'b1);

        // Load 2: random words, then reset in the middle of decode.
        nwords = int'($urandom_range(1, 6));
        for (int i = 0; i < nwords; i++) begin
            uart_word(18'($urandom), int'($urandom_range(1, 3)));
            uart_idle(int'($urandom_range(1, 3)), 1'b1);
        end
        n = 0;
        while (phase != P_DEC && n < 4 * T) begin
            uart_idle(1, 1'b1);
            n++;
        end
        check("load2_decode", 32'(bus.Owner), 32'd2);
        check("load2_words", 32'(bus.Word_count), 32'(nwords));
        uart_idle(int'($urandom_range(2, 8)), 1'b0);
        bus.DEC_SRAM_we_n = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check("mid_rst_owner", 32'(bus.Owner), 32'd0);
        check("mid_rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
        check("mid_rst_ctrl", 32'({bus.UART_initialize, bus.UART_enable,
                                   bus.DEC_start, bus.VGA_enable, bus.Busy}), 32'd0);
        check("mid_rst_count", 32'(bus.Word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        uart_idle(2, 1'b0);

        // Load 3: no writes ever, so the load never times out.
        pulse_start();
        uart_idle(3 * T, 1'b1);
        check("no_write_busy", 32'(bus.Busy), 32'd1);
        check("no_write_owner", 32'(bus.Owner), 32'd1);
        check("no_write_enable", 32'(bus.UART_enable), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_owner_sequencer.md
# sram_owner_sequencer

Top-level sequencer and SRAM port multiplexer for the bitstream-to-video flow. It runs three phases in order: UART load of the compressed bitstream into SRAM, decode, then VGA display. During each phase it hands the single external SRAM port to exactly one master. It drives the UART loader's Initialize/Enable, detects end-of-transfer by UART idle timeout, pulses the decoder start, and enables the VGA reader.

## Interface
- TIMEOUT_CYCLES, default 50_000_000: idle cycles after the last UART write that end the load phase (minimum 2).
- CNT_W, default 26: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clock  in  1  system clock.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle start/restart request.
- UART_SRAM_address  in  18  UART loader address.
- UART_SRAM_write_data  in  16  UART loader write data.
- UART_SRAM_we_n  in  1  UART loader write enable, active-low.
- DEC_SRAM_address  in  18  decoder address.
- DEC_SRAM_write_data  in  16  decoder write data.
- DEC_SRAM_we_n  in  1  decoder write enable, active-low.
- DEC_done  in  1  single-cycle decode-complete pulse.
- VGA_SRAM_address  in  18  VGA reader address; read-only master.
- SRAM_address  out  18  muxed SRAM address.
- SRAM_write_data  out  16  muxed SRAM write data.
- SRAM_we_n  out  1  muxed SRAM write enable, active-low.
- UART_initialize  out  1  Initialize to the UART loader.
- UART_enable  out  1  Enable to the UART loader.
- DEC_start  out  1  single-cycle decoder start pulse.
- VGA_enable  out  1  VGA reader enable.
- Owner  out  2  current SRAM owner: 0 none, 1 UART, 2 decoder, 3 VGA.
- Word_count  out  18  number of UART words written in the current load.
- Busy  out  1  high in any state other than S_IDLE and S_DISPLAY.

## Operation
- States: S_IDLE, S_UART_INIT, S_UART_RX, S_GUARD_A, S_DECODE, S_GUARD_B, S_DISPLAY.
- S_IDLE: Owner=0. When Start=1, go to S_UART_INIT.
- S_UART_INIT (1 cycle):
  - UART_initialize=1, Owner=1.
  - Clear Word_count and the timeout counter; clear the seen_write flag.
  - Go to S_UART_RX.
- S_UART_RX:
  - UART_enable=1, Owner=1.
  - A UART_SRAM_we_n 1→0 transition (registered previous value compared) increments Word_count (wraps at 2^18) and sets seen_write.
  - Timeout counter clears on any cycle with UART_SRAM_we_n=0. Otherwise it increments while seen_write=1.
  - When the counter reaches TIMEOUT_CYCLES-1, go to S_GUARD_A.
  - With no write ever seen, the block stays in S_UART_RX indefinitely.
- S_GUARD_A (1 cycle): Owner=0, UART_enable=0. Go to S_DECODE.
- S_DECODE:
  - Owner=2. DEC_start=1 on the first cycle in the state only.
  - DEC_done is ignored on that first cycle and sampled from the second cycle on. On DEC_done=1, go to S_GUARD_B.
- S_GUARD_B (1 cycle): Owner=0. Go to S_DISPLAY.
- S_DISPLAY:
  - Owner=3, VGA_enable=1.
  - Start=1 restarts the flow: go to S_UART_INIT, and VGA_enable drops the same edge.
- Start is ignored in every state except S_IDLE and S_DISPLAY.
- Mux (combinational from the registered Owner):
  - Owner 1 passes the UART signals; Owner 2 passes the decoder signals.
  - Owner 3: SRAM_address=VGA_SRAM_address, SRAM_write_data=0, SRAM_we_n=1.
  - Owner 0: address 0, data 0, SRAM_we_n=1.
- SRAM_we_n is never 0 in S_IDLE, the guard states or S_DISPLAY, whatever the master inputs do.
- Reset values: state S_IDLE, Owner 0, all control outputs 0, Word_count 0, counter 0, SRAM_we_n 1, SRAM_address 0, SRAM_write_data 0.
- Reset is honoured mid-phase; the block returns to S_IDLE immediately.

## Timing
- Start at edge n → S_UART_INIT in cycle n+1 (UART_initialize high for exactly one cycle) → UART_enable high from cycle n+2.
- Last UART write cycle w → counter reaches TIMEOUT_CYCLES-1 at cycle w+TIMEOUT_CYCLES-1 → S_GUARD_A one cycle later → DEC_start high in the cycle after that.
- DEC_done at cycle d → S_GUARD_B at d+1 → VGA_enable and Owner=3 at d+2.
- All control outputs are registered. SRAM mux outputs add zero cycles of latency from the master inputs.
- A UART write arriving at the same edge the counter would expire clears the counter; the load does not end.

## Test plan
- Reset mid S_DECODE → next cycle Owner=0, SRAM_we_n=1, all control outputs 0, state S_IDLE.
- TIMEOUT_CYCLES=8, Start, then 4 UART words (we_n low 2 cycles each, addresses 76800..76803) → Word_count=4, SRAM mirrors the UART signals, S_GUARD_A exactly 8 cycles after the last we_n low, DEC_start a single 1-cycle pulse.
- In S_DECODE, hold DEC_SRAM_we_n=0 and DEC_done=1 on the first cycle → done ignored. Assert DEC_done 10 cycles later → S_GUARD_B shows SRAM_we_n=1 despite the decoder driving 0 → VGA_enable=1 two cycles after done.
- In S_DISPLAY, drive VGA_SRAM_address=0x12C00 with UART_SRAM_we_n=0 → SRAM_address=0x12C00, SRAM_we_n=1.
- Start while in S_UART_RX → ignored. Start in S_DISPLAY → UART_initialize pulse, Word_count cleared to 0, VGA_enable low.
- After Start, drive no UART writes for 3×TIMEOUT_CYCLES → the block stays in S_UART_RX with Busy=1.
